// File: rtl/imgwriter_pkg.sv
// imgwriter_pkg: shared types and default widths for the framebuffer writer.
//   state_t      : writer FSM states (IDLE, LINE, DRAIN, ERR)
//   DEF_*        : default parameter values used by imgwriter and its sub-module
//   DEF_CNTW     : beat/ack counter width derived from DEF_LGLEN
//   DEF_LINEW    : line-count register width derived from DEF_LW
package imgwriter_pkg;

  localparam int unsigned DEF_AW    = 24;
  localparam int unsigned DEF_BUSW  = 32;
  localparam int unsigned DEF_LGLEN = 11;
  localparam int unsigned DEF_LW    = 11;
  localparam int unsigned DEF_CNTW  = DEF_LGLEN + 1;
  localparam int unsigned DEF_LINEW = DEF_LW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LINE  = 2'd1,
    DRAIN = 2'd2,
    ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/imgwriter_if.sv
// imgwriter_if: pipelined Wishbone write bus between imgwriter and memory.
//   cyc, stb, we, addr, data, sel : driven by the master
//   ack, stall, err               : driven by the slave
// Modports: master (bus initiator), slave (memory / interconnect side).
interface imgwriter_if #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 32
) ();

  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   data;
  logic [DW/8-1:0] sel;
  logic            ack;
  logic            stall;
  logic            err;

  modport master (
    output cyc, stb, we, addr, data, sel,
    input  ack, stall, err
  );

  modport slave (
    input  cyc, stb, we, addr, data, sel,
    output ack, stall, err
  );

endinterface

// File: rtl/imgwriter_wbbeat_tracker.sv
// wbbeat_tracker: counts beats issued and acks received within one bus cycle.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : new-frame abort, zeroes both counters
//   cyc          : registered cycle flag of the master; counters clear while low
//   accept       : a stream word was taken for the bus this cycle
//   ack          : Wishbone ack (counted only while cyc is high)
//   linewords    : words per line to compare against
//   beats, acks  : current counts
//   last_beat    : registered, the next accepted word is the final one of the line
//   last_ack     : registered, the next ack is the final one of the line
module wbbeat_tracker
  import imgwriter_pkg::*;
#(
  parameter int unsigned CNTW = DEF_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            cyc,
  input  logic            accept,
  input  logic            ack,
  input  logic [CNTW-1:0] linewords,
  output logic [CNTW-1:0] beats,
  output logic [CNTW-1:0] acks,
  output logic            last_beat,
  output logic            last_ack
);

  localparam int unsigned EW = CNTW + 1;

  logic [CNTW-1:0] beats_n;
  logic [CNTW-1:0] acks_n;

  function automatic logic next_is_final(input logic [CNTW-1:0] cnt,
                                         input logic [CNTW-1:0] lw);
    return (EW'(cnt) + EW'(1)) == EW'(lw);
  endfunction

  // The first word of a line is accepted while cyc is still low, so an
  // accept takes priority over the idle clear and counts from zero.
  always_comb begin
    beats_n = beats;
    acks_n  = acks;
    if (clear) begin
      beats_n = '0;
      acks_n  = '0;
    end else begin
      if (accept)
        beats_n = (cyc ? beats : '0) + CNTW'(1);
      else if (!cyc)
        beats_n = '0;
      if (!cyc)
        acks_n = '0;
      else if (ack)
        acks_n = acks + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beats     <= '0;
      acks      <= '0;
      last_beat <= 1'b0;
      last_ack  <= 1'b0;
    end else begin
      beats     <= beats_n;
      acks      <= acks_n;
      last_beat <= next_is_final(beats_n, linewords);
      last_ack  <= next_is_final(acks_n, linewords);
    end
  end

endmodule

// File: rtl/imgwriter.sv
// imgwriter: pipelined Wishbone master writing a pixel-word stream into a
// contiguous framebuffer (nlines lines of linewords words from a base address),
// one bus cycle per line.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_newframe            : abort current activity, latch parameters, start frame
//   i_baseaddr            : frame base word address
//   i_linewords, i_nlines : frame geometry
//   i_valid/o_ready/i_word: input stream handshake and data
//   wb                    : Wishbone master port (imgwriter_if.master)
//   o_busy                : high while in LINE or DRAIN
//   o_frame_done, o_err   : one-cycle completion / bus-error pulses
module imgwriter
  import imgwriter_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_AW,
  parameter int unsigned BUSW          = DEF_BUSW,
  parameter int unsigned LGLEN         = DEF_LGLEN,
  parameter int unsigned LW            = DEF_LW
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_newframe,
  input  logic [ADDRESS_WIDTH-1:0] i_baseaddr,
  input  logic [LGLEN:0]           i_linewords,
  input  logic [LW-1:0]            i_nlines,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [BUSW-1:0]          i_word,
  imgwriter_if.master              wb,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_err
);

  localparam int unsigned CNTW = LGLEN + 1;
  localparam int unsigned LEW  = LW + 1;

  state_t                   state, state_n;
  logic                     cyc, cyc_n;
  logic                     stb, stb_n;
  logic [ADDRESS_WIDTH-1:0] addr, addr_n;
  logic [BUSW-1:0]          data, data_n;
  logic [CNTW-1:0]          lw_q, lw_n;
  logic [LW-1:0]            nl_q, nl_n;
  logic [LW-1:0]            line, line_n;
  logic                     done_n, err_n;

  logic [CNTW-1:0]          beats, acks;
  logic                     last_beat, last_ack;
  logic                     accept;
  logic                     retire;

  assign accept = i_valid && o_ready;
  assign retire = stb && !wb.stall;

  wbbeat_tracker #(
    .CNTW (CNTW)
  ) u_tracker (
    .clk       (i_clk),
    .reset     (i_reset),
    .clear     (i_newframe),
    .cyc       (cyc),
    .accept    (accept && (state == LINE)),
    .ack       (wb.ack),
    .linewords (i_newframe ? i_linewords : lw_q),
    .beats     (beats),
    .acks      (acks),
    .last_beat (last_beat),
    .last_ack  (last_ack)
  );

  // A new frame drops the bus in the same cycle, so cyc/stb are gated
  // combinationally rather than waiting for the register to clear.
  assign wb.cyc  = cyc && !i_newframe;
  assign wb.stb  = stb && !i_newframe;
  assign wb.we   = 1'b1;
  assign wb.sel  = '1;
  assign wb.addr = addr;
  assign wb.data = data;
  assign o_busy  = (state == LINE) || (state == DRAIN);

  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    stb_n   = stb;
    addr_n  = addr;
    data_n  = data;
    lw_n    = lw_q;
    nl_n    = nl_q;
    line_n  = line;
    done_n  = 1'b0;
    err_n   = 1'b0;
    o_ready = 1'b0;

    // Words are refused during reset and new-frame cycles so none are lost.
    if (!i_reset && !i_newframe) begin
      unique case (state)
        LINE:    o_ready = (!stb || !wb.stall) && (beats < lw_q);
        ERR:     o_ready = 1'b1;
        default: o_ready = 1'b0;
      endcase
    end

    if (i_newframe) begin
      cyc_n  = 1'b0;
      stb_n  = 1'b0;
      lw_n   = i_linewords;
      nl_n   = i_nlines;
      addr_n = i_baseaddr;
      line_n = '0;
      if ((i_linewords == '0) || (i_nlines == '0)) begin
        done_n  = 1'b1;
        state_n = IDLE;
      end else begin
        state_n = LINE;
      end
    end else if (cyc && wb.err) begin
      cyc_n   = 1'b0;
      stb_n   = 1'b0;
      err_n   = 1'b1;
      state_n = ERR;
    end else begin
      if (retire)
        addr_n = addr + ADDRESS_WIDTH'(1);
      unique case (state)
        LINE: begin
          if (accept) begin
            cyc_n  = 1'b1;
            stb_n  = 1'b1;
            data_n = i_word;
            if (last_beat)
              state_n = DRAIN;
          end else if (retire) begin
            stb_n = 1'b0;
          end
        end
        DRAIN: begin
          if (retire)
            stb_n = 1'b0;
          if (cyc && wb.ack && last_ack) begin
            cyc_n  = 1'b0;
            line_n = line + LW'(1);
            if ((LEW'(line) + LEW'(1)) == LEW'(nl_q)) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = LINE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      cyc          <= 1'b0;
      stb          <= 1'b0;
      addr         <= '0;
      data         <= '0;
      lw_q         <= '0;
      nl_q         <= '0;
      line         <= '0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= state_n;
      cyc          <= cyc_n;
      stb          <= stb_n;
      addr         <= addr_n;
      data         <= data_n;
      lw_q         <= lw_n;
      nl_q         <= nl_n;
      line         <= line_n;
      o_frame_done <= done_n;
      o_err        <= err_n;
    end
  end

endmodule

// File: tb/tb_imgwriter.sv
// tb_imgwriter: directed self-checking bench for imgwriter.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_imgwriter;

  localparam int unsigned AW    = 24;
  localparam int unsigned DW    = 32;
  localparam int unsigned LGLEN = 11;
  localparam int unsigned LW    = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_reset, i_newframe, i_valid, o_ready;
  logic          o_busy, o_frame_done, o_err;
  logic [AW-1:0] i_baseaddr;
  logic [LGLEN:0] i_linewords;
  logic [LW-1:0] i_nlines;
  logic [DW-1:0] i_word;

  imgwriter_if #(.AW(AW), .DW(DW)) wb ();

  imgwriter #(
    .ADDRESS_WIDTH (AW),
    .BUSW          (DW),
    .LGLEN         (LGLEN),
    .LW            (LW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_newframe   (i_newframe),
    .i_baseaddr   (i_baseaddr),
    .i_linewords  (i_linewords),
    .i_nlines     (i_nlines),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_word       (i_word),
    .wb           (wb),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_err        (o_err)
  );

  // next-cycle stimulus
  logic           nx_reset = 1'b0, nx_nf = 1'b0, nx_valid = 1'b0, nx_stall = 1'b0;
  logic           nx_ack_en = 1'b1, nx_ack_force = 1'b0;
  logic [AW-1:0]  nx_base = '0;
  logic [LGLEN:0] nx_lw = '0;
  logic [LW-1:0]  nx_nl = '0;
  int             err_at = 0;

  // observation log
  int            checks = 0, errors = 0;
  int            cyc_no = 0, acc = 0, acc0 = 0;
  int            n_wr = 0, ack_total = 0, fall_cnt = 0, rise_cnt = 0, stb_cnt = 0;
  int            fd_cnt = 0, fd_cyc = 0, fd_acks = 0, last_ack_cyc = 0;
  int            err_cnt = 0, err_cyc = 0, err_inj_cyc = 0;
  logic          hs_prev = 1'b0, cyc_last = 1'b0;
  logic [AW-1:0] wr_addr [64];
  logic [DW-1:0] wr_data [64];
  int            fall_acks [8];

  function automatic logic [DW-1:0] word(input int k);
    return 32'hA500_0000 + DW'(k);
  endfunction

  task automatic tick();
    @(negedge clk);
    i_reset     = nx_reset;
    i_newframe  = nx_nf;
    i_baseaddr  = nx_base;
    i_linewords = nx_lw;
    i_nlines    = nx_nl;
    i_valid     = nx_valid;
    i_word      = word(acc);
    wb.stall    = nx_stall;
    wb.ack      = nx_ack_force || (nx_ack_en && hs_prev);
    wb.err      = 1'b0;
    #1;
    cyc_no++;
    if (err_at != 0 && wb.ack && wb.cyc && (ack_total + 1 == err_at)) begin
      wb.err = 1'b1;
      err_inj_cyc = cyc_no;
    end
    hs_prev = wb.cyc && wb.stb && !wb.stall;
    if (hs_prev && n_wr < 64) begin
      wr_addr[n_wr] = wb.addr;
      wr_data[n_wr] = wb.data;
      n_wr++;
    end
    if (cyc_last && !wb.cyc) begin
      if (fall_cnt < 8) fall_acks[fall_cnt] = ack_total;
      fall_cnt++;
    end
    if (!cyc_last && wb.cyc) rise_cnt++;
    cyc_last = wb.cyc;
    if (wb.stb) stb_cnt++;
    if (wb.ack && wb.cyc) begin
      ack_total++;
      last_ack_cyc = cyc_no;
    end
    if (i_valid && o_ready) acc++;
    if (o_frame_done) begin
      if (fd_cnt == 0) begin
        fd_cyc  = cyc_no;
        fd_acks = ack_total;
      end
      fd_cnt++;
    end
    if (o_err) begin
      if (err_cnt == 0) err_cyc = cyc_no;
      err_cnt++;
    end
  endtask

  task automatic clear_log();
    n_wr = 0; ack_total = 0; fall_cnt = 0; rise_cnt = 0; stb_cnt = 0;
    fd_cnt = 0; err_cnt = 0; acc0 = acc;
  endtask

  task automatic start_frame(input logic [AW-1:0] base, input int lw, input int nl);
    nx_base = base; nx_lw = (LGLEN+1)'(lw); nx_nl = LW'(nl);
    nx_nf = 1'b1;
    tick();
    nx_nf = 1'b0;
  endtask

  task automatic wait_frame_done(input string name);
    for (int t = 0; t < 200 && fd_cnt == 0; t++) tick();
    checks++;
    if (fd_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: frame_done count %0d, required >= 1", name, fd_cnt);
    end
    repeat (4) tick();
  endtask

  task automatic check_writes(input string name, input int first, input int cnt,
                              input logic [AW-1:0] base, input int widx);
    for (int i = 0; i < cnt; i++) begin
      checks++;
      if (wr_addr[first+i] !== base + AW'(i) || wr_data[first+i] !== word(widx + i)) begin
        errors++;
        $display("FAIL %s_write%0d: addr %h data %h, required addr %h data %h", name, i,
                 wr_addr[first+i], wr_data[first+i], base + AW'(i), word(widx + i));
      end
    end
  endtask

  task automatic test_reset();
    nx_reset = 1'b1;
    repeat (2) tick();
    nx_reset = 1'b0;
    tick();
    checks++;
    if ({wb.cyc, wb.stb, o_ready, o_busy, o_frame_done, o_err} !== 6'b0 ||
        wb.addr !== '0 || wb.data !== '0 || wb.we !== 1'b1 || wb.sel !== 4'hF) begin
      errors++;
      $display("FAIL reset_state: cyc%b stb%b rdy%b busy%b fd%b err%b addr %h data %h we%b sel %h, required all zero, we 1, sel f",
               wb.cyc, wb.stb, o_ready, o_busy, o_frame_done, o_err, wb.addr, wb.data, wb.we, wb.sel);
    end
  endtask

  task automatic test_two_lines();
    clear_log();
    nx_ack_en = 1'b1; nx_valid = 1'b1; nx_stall = 1'b0;
    start_frame(24'h001000, 4, 2);
    wait_frame_done("two_lines");
    checks++;
    if (n_wr !== 8) begin
      errors++; $display("FAIL two_lines_count: %0d writes, required 8", n_wr);
    end
    check_writes("two_lines", 0, 8, 24'h001000, acc0);
    checks++;
    if (fall_cnt !== 2 || fall_acks[0] !== 4 || fall_acks[1] !== 8) begin
      errors++;
      $display("FAIL two_lines_cyc_drop: falls %0d at acks %0d/%0d, required 2 at 4/8",
               fall_cnt, fall_acks[0], fall_acks[1]);
    end
    checks++;
    if (fd_cnt !== 1 || fd_acks !== 8 || fd_cyc !== last_ack_cyc + 1) begin
      errors++;
      $display("FAIL two_lines_done: pulses %0d acks %0d cycle %0d, required 1 pulse after 8 acks at cycle %0d",
               fd_cnt, fd_acks, fd_cyc, last_ack_cyc + 1);
    end
    checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b0) begin
      errors++; $display("FAIL two_lines_idle: busy %b ready %b, required 0 0", o_busy, o_ready);
    end
  endtask

  task automatic test_stall();
    clear_log();
    start_frame(24'h001000, 4, 2);
    for (int t = 1; t < 200 && fd_cnt == 0; t++) begin
      nx_stall = (t >= 3 && t <= 5);
      tick();
      if (t >= 3 && t <= 5) begin
        checks++;
        if (wb.stb !== 1'b1 || wb.addr !== 24'h001001 || wb.data !== word(acc0 + 1) || o_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold_t%0d: stb %b addr %h data %h ready %b, required 1 001001 %h 0",
                   t, wb.stb, wb.addr, wb.data, o_ready, word(acc0 + 1));
        end
      end
    end
    nx_stall = 1'b0;
    wait_frame_done("stall");
    checks++;
    if (n_wr !== 8 || fd_cnt !== 1) begin
      errors++; $display("FAIL stall_count: %0d writes %0d done, required 8 1", n_wr, fd_cnt);
    end
    check_writes("stall", 0, 8, 24'h001000, acc0);
  endtask

  task automatic test_bus_error();
    int a0, s0;
    clear_log();
    err_at = 3;
    start_frame(24'h003000, 4, 2);
    for (int t = 0; t < 100 && err_cnt == 0; t++) tick();
    err_at = 0;
    checks++;
    if (err_cnt !== 1 || err_cyc !== err_inj_cyc + 1 || wb.cyc !== 1'b0 || wb.stb !== 1'b0) begin
      errors++;
      $display("FAIL bus_error_abort: err pulses %0d at cycle %0d cyc %b stb %b, required 1 at %0d, 0 0",
               err_cnt, err_cyc, wb.cyc, wb.stb, err_inj_cyc + 1);
    end
    a0 = acc; s0 = stb_cnt;
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++;
      if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
        errors++; $display("FAIL bus_error_sink_t%0d: ready %b busy %b, required 1 0", t, o_ready, o_busy);
      end
    end
    checks++;
    if (acc - a0 !== 10 || stb_cnt !== s0 || err_cnt !== 1 || rise_cnt !== 1) begin
      errors++;
      $display("FAIL bus_error_quiet: discarded %0d stb %0d err %0d rises %0d, required 10 %0d 1 1",
               acc - a0, stb_cnt, err_cnt, rise_cnt, s0);
    end
  endtask

  task automatic test_newframe_abort();
    int n0, ab;
    clear_log();
    nx_ack_en = 1'b0;
    start_frame(24'h001000, 8, 1);
    repeat (3) tick();
    checks++;
    if (n_wr - ack_total !== 2 || wb.cyc !== 1'b1) begin
      errors++; $display("FAIL abort_setup: outstanding %0d cyc %b, required 2 1", n_wr - ack_total, wb.cyc);
    end
    nx_valid = 1'b0;
    nx_base = 24'h002000; nx_lw = 12'd4; nx_nl = 11'd1;
    nx_nf = 1'b1;
    tick();
    nx_nf = 1'b0;
    checks++;
    if (wb.cyc !== 1'b0 || wb.stb !== 1'b0) begin
      errors++; $display("FAIL abort_drop: cyc %b stb %b, required 0 0", wb.cyc, wb.stb);
    end
    nx_ack_force = 1'b1;
    repeat (2) tick();
    nx_ack_force = 1'b0;
    checks++;
    if (wb.cyc !== 1'b0) begin
      errors++; $display("FAIL abort_late_ack: cyc %b, required 0", wb.cyc);
    end
    n0 = n_wr; ab = ack_total; acc0 = acc; fd_cnt = 0;
    nx_ack_en = 1'b1; nx_valid = 1'b1;
    wait_frame_done("abort");
    checks++;
    if (n_wr - n0 !== 4 || fd_acks - ab !== 4 || fd_cyc !== last_ack_cyc + 1 || fd_cnt !== 1) begin
      errors++;
      $display("FAIL abort_refill: %0d writes, done after %0d acks at %0d (last ack %0d), %0d pulses, required 4 4 1",
               n_wr - n0, fd_acks - ab, fd_cyc, last_ack_cyc, fd_cnt);
    end
    check_writes("abort", n0, 4, 24'h002000, acc0);
  endtask

  task automatic test_zero_lines();
    clear_log();
    start_frame(24'h004000, 4, 0);
    tick();
    checks++;
    if (o_frame_done !== 1'b1) begin
      errors++; $display("FAIL zero_lines_pulse: frame_done %b, required 1", o_frame_done);
    end
    repeat (8) tick();
    checks++;
    if (fd_cnt !== 1 || rise_cnt !== 0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL zero_lines_quiet: pulses %0d rises %0d busy %b, required 1 0 0", fd_cnt, rise_cnt, o_busy);
    end
    clear_log();
    start_frame(24'h004000, 0, 3);
    repeat (8) tick();
    checks++;
    if (fd_cnt !== 1 || rise_cnt !== 0) begin
      errors++; $display("FAIL zero_words_quiet: pulses %0d rises %0d, required 1 0", fd_cnt, rise_cnt);
    end
  endtask

  task automatic test_reset_midburst();
    clear_log();
    start_frame(24'h005000, 4, 2);
    repeat (3) tick();
    checks++;
    if (wb.stb !== 1'b1 || o_busy !== 1'b1) begin
      errors++; $display("FAIL midburst_setup: stb %b busy %b, required 1 1", wb.stb, o_busy);
    end
    nx_reset = 1'b1;
    tick();
    nx_reset = 1'b0;
    tick();
    checks++;
    if ({wb.cyc, wb.stb, o_ready, o_busy, o_frame_done, o_err} !== 6'b0 ||
        wb.addr !== '0 || wb.data !== '0) begin
      errors++;
      $display("FAIL midburst_reset: cyc%b stb%b rdy%b busy%b fd%b err%b addr %h data %h, required all zero",
               wb.cyc, wb.stb, o_ready, o_busy, o_frame_done, o_err, wb.addr, wb.data);
    end
    stb_cnt = 0;
    repeat (5) tick();
    checks++;
    if (stb_cnt !== 0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL midburst_idle: stb cycles %0d busy %b, required 0 0", stb_cnt, o_busy);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_newframe = 1'b0; i_valid = 1'b0; i_word = '0;
    i_baseaddr = '0; i_linewords = '0; i_nlines = '0;
    wb.ack = 1'b0; wb.stall = 1'b0; wb.err = 1'b0;
    test_reset();
    test_two_lines();
    test_stall();
    test_bus_error();
    test_newframe_abort();
    test_zero_lines();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
